// File: rtl/pipeline_alu_pkg.sv
// Shared types and widths for the 4-stage register-to-memory ALU pipeline.
// Stage bundles carry operands and results between the fetch, exec, writeback and store stages.
package pipeline_alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int MEM_AW = 8;
    localparam int FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        MOVA = 4'd3,
        MOVB = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        NEGA = 4'd8,
        NEGB = 4'd9,
        SRL  = 4'd10,
        SLA  = 4'd11
    } func_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rd;
        logic [FUNC_W-1:0] func;
        logic [MEM_AW-1:0] addr;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] z;
        logic [REG_AW-1:0] rd;
        logic [MEM_AW-1:0] addr;
    } s2_t;

    typedef struct packed {
        logic [DATA_W-1:0] z;
        logic [MEM_AW-1:0] addr;
    } s3_t;

endpackage

// File: rtl/pipeline_alu_exec.sv
// Combinational ALU for the exec stage; arithmetic wraps, opcodes 12-15 yield zero.
module pipeline_alu_exec
    import pipeline_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (func)
            ADD:     result = a + b;
            SUB:     result = a - b;
            MUL:     result = a * b;
            MOVA:    result = a;
            MOVB:    result = b;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            NEGA:    result = '0 - a;
            NEGB:    result = '0 - b;
            SRL:     result = a >> 1;
            SLA:     result = a << 1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_alu_unit.sv
// 4-stage ALU pipeline: operand fetch, exec, regbank writeback, memory store.
// Define FORWARD_EN to bypass the same-edge writeback value into operand fetch.
module pipeline_alu_unit
    import pipeline_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [MEM_AW-1:0] addr,
    output logic [DATA_W-1:0] Z
);

    logic [DATA_W-1:0] regbank [0:(1<<REG_AW)-1];
    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    s1_t s1;
    s2_t s2;
    s3_t s3;

    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] alu_z;

    pipeline_alu_exec u_exec (
        .a      (s1.a),
        .b      (s1.b),
        .func   (s1.func),
        .result (alu_z)
    );

    always_comb begin
        ra = regbank[rs1];
        rb = regbank[rs2];
`ifdef FORWARD_EN
        if (rs1 == s2.rd) ra = s2.z;
        if (rs2 == s2.rd) rb = s2.z;
`endif
    end

    // Arrays are not reset, but writes are suppressed while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            Z  <= '0;
        end else begin
            s1 <= '{a: ra, b: rb, rd: rd, func: func, addr: addr};
            s2 <= '{z: alu_z, rd: s1.rd, addr: s1.addr};
            s3 <= '{z: s2.z, addr: s2.addr};
            Z  <= s3.z;
            regbank[s2.rd] <= s2.z;
            mem[s3.addr]   <= s3.z;
        end
    end

endmodule

// File: tb/tb_pipeline_alu_unit.sv
// Directed bench for pipeline_alu_unit with an expected-Z scoreboard queue.
module tb_pipeline_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] z;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];

`ifdef FORWARD_EN
    localparam logic [15:0] E128 = 16'd3;
    localparam logic [15:0] E130 = 16'd38;
`else
    localparam logic [15:0] E128 = 16'd5;
    localparam logic [15:0] E130 = 16'd37;
`endif

    pipeline_alu_unit dut (
        .clk  (clk),
        .rst  (rst),
        .rs1  (rs1),
        .rs2  (rs2),
        .rd   (rd),
        .func (func),
        .addr (addr),
        .Z    (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r1, input int r2, input int rdv,
                         input int f, input int ad);
        rs1  = r1[3:0];
        rs2  = r2[3:0];
        rd   = rdv[3:0];
        func = f[3:0];
        addr = ad[7:0];
    endtask

    // Z after an edge belongs to the instruction issued three edges earlier.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 4) begin
            e = sb.pop_front();
            if (e.chk) check(e.tag, z, e.exp);
        end
    endtask

    task automatic issue(input int r1, input int r2, input int rdv,
                         input int f, input int ad,
                         input logic [15:0] exp, input string tag);
        drive(r1, r2, rdv, f, ad);
        sb.push_back('{1'b1, exp, tag});
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            issue(0, 0, 9, 12, 255, 16'h0000, "idle_z");
    endtask

    initial begin
        logic [15:0] fexp [0:6];
        fexp[0] = 16'h0000;
        fexp[1] = 16'h0FFF;
        fexp[2] = 16'h0FFF;
        fexp[3] = 16'hFF10;
        fexp[4] = 16'hF0F1;
        fexp[5] = 16'h0078;
        fexp[6] = 16'h01E0;

        rst = 1'b1;
        drive(0, 0, 9, 12, 255);
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", z, 16'h0000);
        rst = 1'b0;
        idle(3);

        for (int k = 0; k < 16; k++) dut.regbank[k] = 16'(k);

        issue(3, 5, 10, 0, 125, 16'd8, "s_add");
        issue(3, 8, 12, 2, 126, 16'd24, "s_mul");
        issue(10, 5, 14, 1, 128, E128, "s_sub_hazard");
        issue(7, 3, 13, 11, 127, 16'd14, "s_sla");
        issue(10, 5, 15, 1, 129, 16'd3, "s_sub");
        issue(12, 13, 16, 0, 130, E130, "s_add_rd16");
        idle(4);

        check("mem125", dut.mem[125], 16'd8);
        check("mem126", dut.mem[126], 16'd24);
        check("mem128", dut.mem[128], E128);
        check("mem127", dut.mem[127], 16'd14);
        check("mem129", dut.mem[129], 16'd3);
        check("mem130", dut.mem[130], E130);
        check("regbank0", dut.regbank[0], E130);

        dut.mem[125] = 16'hAAAA;
        dut.mem[126] = 16'hBBBB;
        dut.regbank[10] = 16'd10;
        issue(3, 5, 9, 0, 250, 16'd8, "pre_add");
        issue(3, 5, 9, 0, 250, 16'd8, "pre_add");
        issue(3, 5, 9, 0, 250, 16'd8, "pre_add");
        issue(3, 5, 10, 0, 125, 16'd8, "r_add");
        issue(3, 8, 12, 2, 126, 16'd24, "r_mul");
        rst = 1'b1;
        #1;
        check("rst_z_async", z, 16'h0000);
        drive(10, 5, 14, 1, 128);
        @(posedge clk);
        #1;
        check("rst_z_held", z, 16'h0000);
        rst = 1'b0;
        sb.delete();
        idle(6);
        check("rst_mem125", dut.mem[125], 16'hAAAA);
        check("rst_mem126", dut.mem[126], 16'hBBBB);
        check("rst_reg10", dut.regbank[10], 16'd10);

        dut.regbank[1] = 16'h00F0;
        dut.regbank[2] = 16'h0F0F;
        dut.regbank[3] = 16'hFFFF;
        dut.regbank[4] = 16'h0001;
        dut.regbank[5] = 16'h0100;
        for (int i = 0; i < 7; i++)
            issue(1, 2, 9, 5 + i, 200 + i, fexp[i], $sformatf("func%0d", 5 + i));
        issue(1, 2, 9, 13, 210, 16'h0000, "func13");
        issue(3, 4, 9, 0, 211, 16'h0000, "add_wrap");
        issue(5, 5, 9, 2, 212, 16'h0000, "mul_wrap");
        issue(2, 1, 9, 1, 213, 16'h0E1F, "sub_basic");
        idle(4);
        check("mem205", dut.mem[205], 16'h0078);
        check("mem213", dut.mem[213], 16'h0E1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
